sap_control_sequencer: RTL and testbench

- Microcoded control unit for the SAP-U 8-bit computer.
- Sequences the memory address register, RAM, instruction register, program counter, A/B registers, ALU and output register over the shared 8-bit bus.
- Runs a T-state step counter and decodes the opcode (instr[7:4]) plus its own latched flags into one control word per clock.
- The datapath samples that control word on the next rising clk edge.

---
 rtl/sap_pkg.sv | 49 ++++
 rtl/sap_microcode_rom.sv | 50 +++++
 rtl/sap_control_sequencer.sv | 112 +++++++++++
 tb/tb_sap_control_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-U control sequencer: opcodes, step count and
// the 16-bit control-word layout.
package sap_pkg;

  localparam int SAP_NUM_STEPS = 5;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef logic [15:0] cw_t;

  localparam logic [3:0] CW_MAR_LOAD_N = 4'd0;
  localparam logic [3:0] CW_RAM_OUT_N  = 4'd1;
  localparam logic [3:0] CW_RAM_IN     = 4'd2;
  localparam logic [3:0] CW_IR_LOAD_N  = 4'd3;
  localparam logic [3:0] CW_IR_OUT_N   = 4'd4;
  localparam logic [3:0] CW_PC_OUT_N   = 4'd5;
  localparam logic [3:0] CW_PC_JUMP_N  = 4'd6;
  localparam logic [3:0] CW_PC_INC     = 4'd7;
  localparam logic [3:0] CW_A_LOAD_N   = 4'd8;
  localparam logic [3:0] CW_A_OUT_N    = 4'd9;
  localparam logic [3:0] CW_B_LOAD_N   = 4'd10;
  localparam logic [3:0] CW_OUT_LOAD_N = 4'd11;
  localparam logic [3:0] CW_ALU_OUT_N  = 4'd12;
  localparam logic [3:0] CW_ALU_SUB    = 4'd13;
  localparam logic [3:0] CW_FLAGS_LOAD = 4'd14;
  // Internal only: marks a step that must be visited even though it drives
  // nothing (HLT T2, untaken JC/JZ T2).
  localparam logic [3:0] CW_KEEP       = 4'd15;

  localparam cw_t CW_IDLE = 16'h1F7B;

  function automatic cw_t cw_on(cw_t w, logic [3:0] idx);
    cw_t r;
    r      = w;
    r[idx] = ~CW_IDLE[idx];
    return r;
  endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word.
module sap_microcode_rom
  import sap_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [2:0] step,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output cw_t        cw
);

  always_comb begin
    cw = CW_IDLE;
    case (step)
      3'd0: cw = cw_on(cw_on(CW_IDLE, CW_PC_OUT_N), CW_MAR_LOAD_N);
      3'd1: cw = cw_on(cw_on(cw_on(CW_IDLE, CW_RAM_OUT_N), CW_IR_LOAD_N), CW_PC_INC);
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA:
                  cw = cw_on(cw_on(CW_IDLE, CW_IR_OUT_N), CW_MAR_LOAD_N);
          OP_LDI: cw = cw_on(cw_on(CW_IDLE, CW_IR_OUT_N), CW_A_LOAD_N);
          OP_JMP: cw = cw_on(cw_on(CW_IDLE, CW_IR_OUT_N), CW_PC_JUMP_N);
          OP_JC:  cw = carry_flag ? cw_on(cw_on(CW_IDLE, CW_IR_OUT_N), CW_PC_JUMP_N)
                                  : cw_on(CW_IDLE, CW_KEEP);
          OP_JZ:  cw = zero_flag  ? cw_on(cw_on(CW_IDLE, CW_IR_OUT_N), CW_PC_JUMP_N)
                                  : cw_on(CW_IDLE, CW_KEEP);
          OP_OUT: cw = cw_on(cw_on(CW_IDLE, CW_A_OUT_N), CW_OUT_LOAD_N);
          OP_HLT: cw = cw_on(CW_IDLE, CW_KEEP);
          default: cw = CW_IDLE;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA:         cw = cw_on(cw_on(CW_IDLE, CW_RAM_OUT_N), CW_A_LOAD_N);
          OP_ADD, OP_SUB: cw = cw_on(cw_on(CW_IDLE, CW_RAM_OUT_N), CW_B_LOAD_N);
          OP_STA:         cw = cw_on(cw_on(CW_IDLE, CW_A_OUT_N), CW_RAM_IN);
          default:        cw = CW_IDLE;
        endcase
      end
      3'd4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw = cw_on(cw_on(cw_on(CW_IDLE, CW_ALU_OUT_N), CW_A_LOAD_N), CW_FLAGS_LOAD);
          if (opcode == OP_SUB) cw = cw_on(cw, CW_ALU_SUB);
        end
      end
      default: cw = CW_IDLE;
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-U control unit: T-state counter, halt latch and flag registers around
// the microcode ROM.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int NUM_STEPS = SAP_NUM_STEPS,
  parameter bit EARLY_END = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       carry_in,
  input  logic       zero_in,
  output logic       mar_load_n,
  output logic       ram_out_n,
  output logic       ram_in,
  output logic       ir_load_n,
  output logic       ir_out_n,
  output logic       pc_out_n,
  output logic       pc_jump_n,
  output logic       pc_inc,
  output logic       a_load_n,
  output logic       a_out_n,
  output logic       b_load_n,
  output logic       out_load_n,
  output logic       alu_out_n,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       halted,
  output logic [2:0] step
);

  logic [3:0] opcode;
  logic [2:0] step_q, step_d, step_inc;
  logic       halted_q, halted_d;
  logic       carry_flag, carry_d, zero_flag, zero_d;
  logic       active, halt_now, next_empty;
  cw_t        cw_cur, cw_nxt, cw;
  logic       unused_bits;

  assign opcode      = instr[7:4];
  assign unused_bits = ^{instr[3:0], cw[CW_KEEP]};
  assign active      = run & ~halted_q & ~clear;
  assign halt_now    = active && (opcode == OP_HLT) && (step_q == 3'd2);
  assign step_inc    = (step_q == 3'(NUM_STEPS - 1)) ? 3'd0 : step_q + 3'd1;

  sap_microcode_rom u_rom_cur (
    .opcode(opcode), .step(step_q), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .cw(cw_cur)
  );

  // Look-ahead copy decides whether the following step has any work.
  sap_microcode_rom u_rom_nxt (
    .opcode(opcode), .step(step_inc), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .cw(cw_nxt)
  );

  assign next_empty = (cw_nxt == CW_IDLE);

  always_ff @(posedge clk) begin
    if (clear) begin
      step_q     <= 3'd0;
      halted_q   <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      step_q     <= step_d;
      halted_q   <= halted_d;
      carry_flag <= carry_d;
      zero_flag  <= zero_d;
    end
  end

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    carry_d  = carry_flag;
    zero_d   = zero_flag;
    if (active) begin
      if (halt_now) halted_d = 1'b1;
      else          step_d   = (EARLY_END && next_empty) ? 3'd0 : step_inc;
      if (cw[CW_FLAGS_LOAD]) begin
        carry_d = carry_in;
        zero_d  = zero_in;
      end
    end
  end

  always_comb begin
    cw = active ? cw_cur : CW_IDLE;
  end

  assign mar_load_n = cw[CW_MAR_LOAD_N];
  assign ram_out_n  = cw[CW_RAM_OUT_N];
  assign ram_in     = cw[CW_RAM_IN];
  assign ir_load_n  = cw[CW_IR_LOAD_N];
  assign ir_out_n   = cw[CW_IR_OUT_N];
  assign pc_out_n   = cw[CW_PC_OUT_N];
  assign pc_jump_n  = cw[CW_PC_JUMP_N];
  assign pc_inc     = cw[CW_PC_INC];
  assign a_load_n   = cw[CW_A_LOAD_N];
  assign a_out_n    = cw[CW_A_OUT_N];
  assign b_load_n   = cw[CW_B_LOAD_N];
  assign out_load_n = cw[CW_OUT_LOAD_N];
  assign alu_out_n  = cw[CW_ALU_OUT_N];
  assign alu_sub    = cw[CW_ALU_SUB];
  assign flags_load = cw[CW_FLAGS_LOAD];
  assign halted     = halted_q;
  assign step       = step_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer (default EARLY_END=1).
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       clear, run, carry_in, zero_in;
  logic [7:0] instr;
  logic       mar_load_n, ram_out_n, ram_in, ir_load_n, ir_out_n, pc_out_n, pc_jump_n;
  logic       pc_inc, a_load_n, a_out_n, b_load_n, out_load_n, alu_out_n, alu_sub;
  logic       flags_load, halted;
  logic [2:0] step;

  int vectors = 0;
  int miscompares = 0;

  // {flags_load, alu_sub, alu_out_n, out_load_n, b_load_n, a_out_n, a_load_n,
  //  pc_inc, pc_jump_n, pc_out_n, ir_out_n, ir_load_n, ram_in, ram_out_n, mar_load_n}
  localparam logic [14:0] IDLE = 15'h1F7B;
  logic [14:0] ctl;
  assign ctl = {flags_load, alu_sub, alu_out_n, out_load_n, b_load_n, a_out_n, a_load_n,
                pc_inc, pc_jump_n, pc_out_n, ir_out_n, ir_load_n, ram_in, ram_out_n, mar_load_n};

  always #5 clk = ~clk;

  sap_control_sequencer dut (
    .clk(clk), .clear(clear), .run(run), .instr(instr),
    .carry_in(carry_in), .zero_in(zero_in),
    .mar_load_n(mar_load_n), .ram_out_n(ram_out_n), .ram_in(ram_in),
    .ir_load_n(ir_load_n), .ir_out_n(ir_out_n), .pc_out_n(pc_out_n),
    .pc_jump_n(pc_jump_n), .pc_inc(pc_inc), .a_load_n(a_load_n), .a_out_n(a_out_n),
    .b_load_n(b_load_n), .out_load_n(out_load_n), .alu_out_n(alu_out_n),
    .alu_sub(alu_sub), .flags_load(flags_load), .halted(halted), .step(step)
  );

  task automatic test_reset();
    clear = 1'b1; run = 1'b0; instr = 8'h00; carry_in = 1'b0; zero_in = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({step, halted} !== {3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state step=%0d halted=%0b exp step=0 halted=0", step, halted);
    end
    vectors++;
    if (ctl !== IDLE) begin
      miscompares++;
      $display("FAIL reset_ctl got=%h exp=%h", ctl, IDLE);
    end
    clear = 1'b0;
  endtask

  task automatic test_ldi();
    logic [2:0] exp_s [0:3];
    exp_s = '{3'd0, 3'd1, 3'd2, 3'd0};
    instr = 8'h57; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (step !== exp_s[i]) begin
        miscompares++;
        $display("FAIL ldi_step[%0d] got=%0d exp=%0d", i, step, exp_s[i]);
      end
      if (i == 0) begin
        vectors++;
        if ({pc_out_n, mar_load_n, ram_out_n} !== 3'b001) begin
          miscompares++;
          $display("FAIL ldi_t0 pc_out_n/mar_load_n/ram_out_n got=%b exp=001",
                   {pc_out_n, mar_load_n, ram_out_n});
        end
      end
      if (i == 1) begin
        vectors++;
        if ({ram_out_n, ir_load_n, pc_inc} !== 3'b001) begin
          miscompares++;
          $display("FAIL ldi_t1 ram_out_n/ir_load_n/pc_inc got=%b exp=001",
                   {ram_out_n, ir_load_n, pc_inc});
        end
      end
      if (i == 2) begin
        vectors++;
        if ({ir_out_n, a_load_n, mar_load_n, halted} !== 4'b0010) begin
          miscompares++;
          $display("FAIL ldi_t2 ir_out_n/a_load_n/mar_load_n/halted got=%b exp=0010",
                   {ir_out_n, a_load_n, mar_load_n, halted});
        end
      end
      if (i < 3) @(negedge clk);
    end
  endtask

  // ADD with carry_in=1/zero_in=0 in T4, then JC taken.
  task automatic test_add_jc();
    instr = 8'h2F; carry_in = 1'b0; zero_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin carry_in = 1'b1; zero_in = 1'b0; end
      #1;
      vectors++;
      if (step !== 3'(i)) begin
        miscompares++;
        $display("FAIL add_step[%0d] got=%0d exp=%0d", i, step, i);
      end
      if (i == 3) begin
        vectors++;
        if ({ram_out_n, b_load_n, a_load_n} !== 3'b001) begin
          miscompares++;
          $display("FAIL add_t3 ram_out_n/b_load_n/a_load_n got=%b exp=001",
                   {ram_out_n, b_load_n, a_load_n});
        end
      end
      if (i == 4) begin
        vectors++;
        if ({alu_out_n, a_load_n, flags_load, alu_sub} !== 4'b0010) begin
          miscompares++;
          $display("FAIL add_t4 alu_out_n/a_load_n/flags_load/alu_sub got=%b exp=0010",
                   {alu_out_n, a_load_n, flags_load, alu_sub});
        end
      end
      @(negedge clk);
    end
    instr = 8'h73; carry_in = 1'b0; zero_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i == 2) begin
        vectors++;
        if ({step, ir_out_n, pc_jump_n} !== {3'd2, 2'b00}) begin
          miscompares++;
          $display("FAIL jc_taken step=%0d ir_out_n/pc_jump_n=%b exp step=2 00",
                   step, {ir_out_n, pc_jump_n});
        end
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (step !== 3'd0) begin
      miscompares++;
      $display("FAIL jc_return got=%0d exp=0", step);
    end
  endtask

  // zero_flag=0 from the ADD above: JZ untaken.
  task automatic test_jz_not_taken();
    logic [2:0] exp_s [0:3];
    exp_s = '{3'd0, 3'd1, 3'd2, 3'd0};
    instr = 8'h85;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (step !== exp_s[i]) begin
        miscompares++;
        $display("FAIL jz_nt_step[%0d] got=%0d exp=%0d", i, step, exp_s[i]);
      end
      if (i == 2) begin
        vectors++;
        if (ctl !== IDLE) begin
          miscompares++;
          $display("FAIL jz_nt_t2 got=%h exp=%h", ctl, IDLE);
        end
      end
      if (i < 3) @(negedge clk);
    end
  endtask

  // SUB loads carry=0, zero=1: JZ taken, JC untaken.
  task automatic test_sub_flags();
    instr = 8'h31; carry_in = 1'b0; zero_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i == 4) begin
        vectors++;
        if ({alu_out_n, flags_load, alu_sub} !== 3'b011) begin
          miscompares++;
          $display("FAIL sub_t4 alu_out_n/flags_load/alu_sub got=%b exp=011",
                   {alu_out_n, flags_load, alu_sub});
        end
      end
      @(negedge clk);
    end
    carry_in = 1'b1; zero_in = 1'b0;
    instr = 8'h85;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i == 2) begin
        vectors++;
        if ({ir_out_n, pc_jump_n} !== 2'b00) begin
          miscompares++;
          $display("FAIL jz_taken got=%b exp=00", {ir_out_n, pc_jump_n});
        end
      end
      @(negedge clk);
    end
    instr = 8'h73;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i == 2) begin
        vectors++;
        if ({step, ctl} !== {3'd2, IDLE}) begin
          miscompares++;
          $display("FAIL jc_untaken step=%0d ctl=%h exp step=2 ctl=%h", step, ctl, IDLE);
        end
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (step !== 3'd0) begin
      miscompares++;
      $display("FAIL jc_untaken_return got=%0d exp=0", step);
    end
  endtask

  task automatic test_sta_pause();
    instr = 8'h4E; carry_in = 1'b0; zero_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      @(negedge clk);
    end
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if ({step, ctl} !== {3'd3, IDLE}) begin
        miscompares++;
        $display("FAIL sta_pause[%0d] step=%0d ctl=%h exp step=3 ctl=%h", k, step, ctl, IDLE);
      end
      @(negedge clk);
    end
    run = 1'b1;
    #1;
    vectors++;
    if ({step, a_out_n, ram_in} !== {3'd3, 2'b01}) begin
      miscompares++;
      $display("FAIL sta_resume step=%0d a_out_n/ram_in=%b exp step=3 01", step, {a_out_n, ram_in});
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({step, a_out_n, ram_in} !== {3'd0, 2'b10}) begin
      miscompares++;
      $display("FAIL sta_after step=%0d a_out_n/ram_in=%b exp step=0 10", step, {a_out_n, ram_in});
    end
  endtask

  // Set both flags, halt, then clear must drop halted, step and flags.
  task automatic test_hlt_clear();
    instr = 8'h2F; carry_in = 1'b1; zero_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      @(negedge clk);
    end
    instr = 8'hF0; carry_in = 1'b0; zero_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i == 2) begin
        vectors++;
        if ({step, halted, ctl} !== {3'd2, 1'b0, IDLE}) begin
          miscompares++;
          $display("FAIL hlt_t2 step=%0d halted=%0b ctl=%h exp 2 0 %h", step, halted, ctl, IDLE);
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 12; k++) begin
      #1;
      vectors++;
      if ({step, halted, ctl} !== {3'd2, 1'b1, IDLE}) begin
        miscompares++;
        $display("FAIL hlt_frozen[%0d] step=%0d halted=%0b ctl=%h exp 2 1 %h",
                 k, step, halted, ctl, IDLE);
      end
      @(negedge clk);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    vectors++;
    if ({step, halted} !== {3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL hlt_clear step=%0d halted=%0b exp 0 0", step, halted);
    end
    instr = 8'h73;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i == 2) begin
        vectors++;
        if (pc_jump_n !== 1'b1) begin
          miscompares++;
          $display("FAIL clear_carry pc_jump_n=%0b exp=1", pc_jump_n);
        end
      end
      @(negedge clk);
    end
    instr = 8'h85;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i == 2) begin
        vectors++;
        if (pc_jump_n !== 1'b1) begin
          miscompares++;
          $display("FAIL clear_zero pc_jump_n=%0b exp=1", pc_jump_n);
        end
      end
      @(negedge clk);
    end
  endtask

  // Every opcode with flags 0 and 1: at most one bus driver per cycle.
  task automatic test_bus_invariant();
    int  nd;
    bit  done;
    for (int f = 0; f < 2; f++) begin
      carry_in = f[0]; zero_in = f[0];
      for (int op = 0; op < 16; op++) begin
        instr = {op[3:0], 4'h3};
        done = 1'b0;
        for (int c = 0; c < 8; c++) begin
          #1;
          nd = int'(!ram_out_n) + int'(!ir_out_n) + int'(!pc_out_n) +
               int'(!a_out_n) + int'(!alu_out_n);
          vectors++;
          if (nd > 1) begin
            miscompares++;
            $display("FAIL bus_drivers op=%h flag=%0d step=%0d drivers=%0d exp<=1", op, f, step, nd);
          end
          if (c > 0 && step == 3'd0) begin
            done = 1'b1;
            break;
          end
          @(negedge clk);
        end
        if (op == 15) begin
          vectors++;
          if (halted !== 1'b1) begin
            miscompares++;
            $display("FAIL bus_hlt halted=%0b exp=1", halted);
          end
          clear = 1'b1;
          @(negedge clk);
          clear = 1'b0;
        end else begin
          vectors++;
          if (!done) begin
            miscompares++;
            $display("FAIL bus_timeout op=%h step=%0d exp return to 0", op, step);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add_jc();
    test_jz_not_taken();
    test_sub_flags();
    test_sta_pause();
    test_hlt_clear();
    test_bus_invariant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
